// File: rtl/dual_port_ram_be.sv
// True dual-port byte-enabled RAM with selectable read-during-write and
// collision priority, optional output register and a collision counter.
module dual_port_ram_be #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RDW_MODE   = 0,
    parameter int PRIORITY   = 0,
    parameter int OUT_REG    = 0,
    parameter int CNT_WIDTH  = 16,
    localparam int NB        = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_a,
    input  logic                  we_a,
    input  logic [NB-1:0]         be_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] din_a,
    output logic [DATA_WIDTH-1:0] dout_a,
    output logic                  valid_a,
    input  logic                  en_b,
    input  logic                  we_b,
    input  logic [NB-1:0]         be_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] din_b,
    output logic [DATA_WIDTH-1:0] dout_b,
    output logic                  valid_b,
    output logic                  collision,
    input  logic                  clr_cnt,
    output logic [CNT_WIDTH-1:0]  collision_cnt
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [NB-1:0]         wbe_a;
    logic [NB-1:0]         wbe_b;
    logic [NB-1:0]         ovl;
    logic                  coll;
    logic [DATA_WIDTH-1:0] old_a;
    logic [DATA_WIDTH-1:0] old_b;
    logic [DATA_WIDTH-1:0] nw_a;
    logic [DATA_WIDTH-1:0] nw_b;
    logic [DATA_WIDTH-1:0] rd_a;
    logic [DATA_WIDTH-1:0] rd_b;

    logic [DATA_WIDTH-1:0] rd_a_q;
    logic [DATA_WIDTH-1:0] rd_b_q;
    logic                  rv_a_q;
    logic                  rv_b_q;
    logic                  coll_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [CNT_WIDTH-1:0]  cnt_d;

    assign wbe_a = {NB{en_a & we_a}} & be_a;
    assign wbe_b = {NB{en_b & we_b}} & be_b;
    assign ovl   = wbe_a & wbe_b & {NB{addr_a == addr_b}};
    assign coll  = |ovl;

    // One byte-wide array per lane; the priority port is written last.
    for (genvar g = 0; g < NB; g++) begin : g_lane
        logic [7:0] m [DEPTH];

        always_ff @(posedge clk) begin
            if (PRIORITY == 0) begin
                if (wbe_b[g]) m[addr_b] <= din_b[g*8 +: 8];
                if (wbe_a[g]) m[addr_a] <= din_a[g*8 +: 8];
            end else begin
                if (wbe_a[g]) m[addr_a] <= din_a[g*8 +: 8];
                if (wbe_b[g]) m[addr_b] <= din_b[g*8 +: 8];
            end
        end

        assign old_a[g*8 +: 8] = m[addr_a];
        assign old_b[g*8 +: 8] = m[addr_b];

        // Own lanes after the write; a lost overlap shows the winner's byte.
        assign nw_a[g*8 +: 8] = !wbe_a[g] ? old_a[g*8 +: 8] :
                                (ovl[g] && PRIORITY != 0) ? din_b[g*8 +: 8] :
                                din_a[g*8 +: 8];
        assign nw_b[g*8 +: 8] = !wbe_b[g] ? old_b[g*8 +: 8] :
                                (ovl[g] && PRIORITY == 0) ? din_a[g*8 +: 8] :
                                din_b[g*8 +: 8];
    end

    assign rd_a = (RDW_MODE != 0) ? nw_a : old_a;
    assign rd_b = (RDW_MODE != 0) ? nw_b : old_b;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (coll && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_a_q <= '0;
            rd_b_q <= '0;
            rv_a_q <= 1'b0;
            rv_b_q <= 1'b0;
            coll_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            rv_a_q <= en_a;
            rv_b_q <= en_b;
            if (en_a) rd_a_q <= rd_a;
            if (en_b) rd_b_q <= rd_b;
            coll_q <= coll;
            cnt_q  <= cnt_d;
        end
    end

    assign collision     = coll_q;
    assign collision_cnt = cnt_q;

    if (OUT_REG != 0) begin : g_oreg
        logic [DATA_WIDTH-1:0] oa_q;
        logic [DATA_WIDTH-1:0] ob_q;
        logic                  ova_q;
        logic                  ovb_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                oa_q  <= '0;
                ob_q  <= '0;
                ova_q <= 1'b0;
                ovb_q <= 1'b0;
            end else begin
                ova_q <= rv_a_q;
                ovb_q <= rv_b_q;
                if (rv_a_q) oa_q <= rd_a_q;
                if (rv_b_q) ob_q <= rd_b_q;
            end
        end

        assign dout_a  = oa_q;
        assign dout_b  = ob_q;
        assign valid_a = ova_q;
        assign valid_b = ovb_q;
    end else begin : g_nreg
        assign dout_a  = rd_a_q;
        assign dout_b  = rd_b_q;
        assign valid_a = rv_a_q;
        assign valid_b = rv_b_q;
    end

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Bench for dual_port_ram_be: two configurations driven in lockstep and
// compared against a word-level model of the memory and its outputs.
module tb_dual_port_ram_be;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        en [2];
    logic        we [2];
    logic [3:0]  be [2];
    logic [7:0]  ad [2];
    logic [31:0] di [2];
    logic        clr;

    logic [31:0] da0, db0, da1, db1;
    logic        va0, vb0, va1, vb1, c0, c1;
    logic [15:0] n0;
    logic [1:0]  n1;

    dual_port_ram_be u0 (
        .clk(clk), .rst_n(rst_n),
        .en_a(en[0]), .we_a(we[0]), .be_a(be[0]), .addr_a(ad[0]),
        .din_a(di[0]), .dout_a(da0), .valid_a(va0),
        .en_b(en[1]), .we_b(we[1]), .be_b(be[1]), .addr_b(ad[1]),
        .din_b(di[1]), .dout_b(db0), .valid_b(vb0),
        .collision(c0), .clr_cnt(clr), .collision_cnt(n0)
    );

    dual_port_ram_be #(
        .RDW_MODE(1), .PRIORITY(1), .OUT_REG(1), .CNT_WIDTH(2)
    ) u1 (
        .clk(clk), .rst_n(rst_n),
        .en_a(en[0]), .we_a(we[0]), .be_a(be[0]), .addr_a(ad[0]),
        .din_a(di[0]), .dout_a(da1), .valid_a(va1),
        .en_b(en[1]), .we_b(we[1]), .be_b(be[1]), .addr_b(ad[1]),
        .din_b(di[1]), .dout_b(db1), .valid_b(vb1),
        .collision(c1), .clr_cnt(clr), .collision_cnt(n1)
    );

    // Model state: index 0 is u0 (defaults), 1 is u1.
    logic [31:0] mm [2][256];
    logic [31:0] od [2][2];
    logic [31:0] pd [2][2];
    logic        ov [2][2];
    logic        pv [2][2];
    logic        ecol;
    int          ecnt [2];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Word at address a after this edge's writes; the losing port goes first.
    function automatic logic [31:0] after_wr(int c, logic [7:0] a,
                                             logic [31:0] w);
        logic [31:0] r;
        int first;
        int p;
        r = w;
        first = (c == 0) ? 1 : 0;
        for (int k = 0; k < 2; k++) begin
            p = (k == 0) ? first : 1 - first;
            if (en[p] && we[p] && ad[p] == a)
                for (int i = 0; i < 4; i++)
                    if (be[p][i]) r[i*8 +: 8] = di[p][i*8 +: 8];
        end
        return r;
    endfunction

    task automatic model_edge();
        logic [31:0] rd [2];
        logic [31:0] nw [2];
        logic        col;
        int          cmax;
        col = en[0] && we[0] && en[1] && we[1] && ad[0] == ad[1]
              && (be[0] & be[1]) != 4'h0;
        for (int c = 0; c < 2; c++) begin
            for (int p = 0; p < 2; p++) begin
                nw[p] = after_wr(c, ad[p], mm[c][ad[p]]);
                rd[p] = mm[c][ad[p]];
                if (c == 1 && en[p] && we[p])
                    for (int i = 0; i < 4; i++)
                        if (be[p][i]) rd[p][i*8 +: 8] = nw[p][i*8 +: 8];
            end
            for (int p = 0; p < 2; p++) mm[c][ad[p]] = nw[p];
            for (int p = 0; p < 2; p++) begin
                if (c == 0) begin
                    ov[c][p] = en[p];
                    if (en[p]) od[c][p] = rd[p];
                end else begin
                    ov[c][p] = pv[c][p];
                    if (pv[c][p]) od[c][p] = pd[c][p];
                    pv[c][p] = en[p];
                    if (en[p]) pd[c][p] = rd[p];
                end
            end
            cmax = (c == 0) ? 65535 : 3;
            if (clr) ecnt[c] = 0;
            else if (col && ecnt[c] < cmax) ecnt[c]++;
        end
        ecol = col;
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int p = 0; p < 2; p++) begin
                od[c][p] = '0;
                pd[c][p] = '0;
                ov[c][p] = 1'b0;
                pv[c][p] = 1'b0;
            end
            ecnt[c] = 0;
        end
        ecol = 1'b0;
    endtask

    task automatic chk_all();
        chk("u0.dout_a", da0, od[0][0]);
        chk("u0.valid_a", {31'b0, va0}, {31'b0, ov[0][0]});
        chk("u0.dout_b", db0, od[0][1]);
        chk("u0.valid_b", {31'b0, vb0}, {31'b0, ov[0][1]});
        chk("u0.collision", {31'b0, c0}, {31'b0, ecol});
        chk("u0.cnt", {16'b0, n0}, ecnt[0]);
        chk("u1.dout_a", da1, od[1][0]);
        chk("u1.valid_a", {31'b0, va1}, {31'b0, ov[1][0]});
        chk("u1.dout_b", db1, od[1][1]);
        chk("u1.valid_b", {31'b0, vb1}, {31'b0, ov[1][1]});
        chk("u1.collision", {31'b0, c1}, {31'b0, ecol});
        chk("u1.cnt", {30'b0, n1}, ecnt[1]);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk_all();
    endtask

    task automatic set(int p, logic e, logic w, logic [3:0] b,
                       logic [7:0] a, logic [31:0] d);
        en[p] = e;
        we[p] = w;
        be[p] = b;
        ad[p] = a;
        di[p] = d;
    endtask

    task automatic idle();
        set(0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        set(1, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all();
        rst_n = 1'b1;

        for (int a = 0; a < 256; a++) begin
            set(0, 1'b1, 1'b1, 4'hf, 8'(a), $urandom);
            step();
        end
        idle();
        step();

        // Byte-lane write
        set(0, 1'b1, 1'b1, 4'hf, 8'h10, 32'hAABBCCDD); step();
        set(0, 1'b1, 1'b1, 4'h3, 8'h10, 32'h00001122); step();
        set(0, 1'b1, 1'b0, 4'h0, 8'h10, 32'h0); step();
        chk("bytelane.u0", da0, 32'hAABB1122);
        chk("bytelane.u0.v", {31'b0, va0}, 32'h1);
        idle(); step();
        chk("bytelane.u1", da1, 32'hAABB1122);
        chk("bytelane.u1.v", {31'b0, va1}, 32'h1);
        chk("bytelane.u0.idle", {31'b0, va0}, 32'h0);

        // Same-port read-during-write
        set(0, 1'b1, 1'b1, 4'hf, 8'h20, 32'h11111111); step();
        set(0, 1'b1, 1'b1, 4'hf, 8'h20, 32'h22222222); step();
        chk("rdw.u0", da0, 32'h11111111);
        idle(); step();
        chk("rdw.u1", da1, 32'h22222222);

        // Cross-port read-during-write
        set(0, 1'b1, 1'b1, 4'hf, 8'h20, 32'h33333333);
        set(1, 1'b1, 1'b0, 4'h0, 8'h20, 32'h0); step();
        chk("xrdw.u0", db0, 32'h22222222);
        idle();
        set(1, 1'b1, 1'b0, 4'h0, 8'h20, 32'h0); step();
        chk("xrdw2.u0", db0, 32'h33333333);
        chk("xrdw.u1", db1, 32'h22222222);
        idle(); step();
        chk("xrdw2.u1", db1, 32'h33333333);

        // Collision merge
        clr = 1'b1; step(); idle();
        set(0, 1'b1, 1'b1, 4'hf, 8'h30, 32'h01020304); step();
        set(0, 1'b1, 1'b1, 4'hc, 8'h30, 32'hCCCCCCCC);
        set(1, 1'b1, 1'b1, 4'h6, 8'h30, 32'hDDDDDDDD); step();
        chk("coll.u0.pulse", {31'b0, c0}, 32'h1);
        chk("coll.u1.pulse", {31'b0, c1}, 32'h1);
        chk("coll.u0.cnt", {16'b0, n0}, 32'h1);
        idle();
        set(0, 1'b1, 1'b0, 4'h0, 8'h30, 32'h0); step();
        chk("coll.u0.drop", {31'b0, c0}, 32'h0);
        chk("coll.u0.word", da0, 32'hCCCCDD04);
        idle(); step();
        chk("coll.u1.word", da1, 32'hCCDDDD04);

        // Disjoint lanes at one address
        set(0, 1'b1, 1'b1, 4'hc, 8'h40, 32'hAAAAAAAA);
        set(1, 1'b1, 1'b1, 4'h3, 8'h40, 32'hBBBBBBBB); step();
        chk("disj.nocoll", {31'b0, c0}, 32'h0);
        idle();
        set(0, 1'b1, 1'b0, 4'h0, 8'h40, 32'h0); step();
        chk("disj.u0", da0, 32'hAAAABBBB);
        idle(); step();
        chk("disj.u1", da1, 32'hAAAABBBB);

        // Counter saturation and clear-wins
        clr = 1'b1; step(); idle();
        for (int k = 0; k < 5; k++) begin
            set(0, 1'b1, 1'b1, 4'h1, 8'h50, $urandom);
            set(1, 1'b1, 1'b1, 4'h1, 8'h50, $urandom);
            step();
        end
        chk("sat.u1", {30'b0, n1}, 32'h3);
        chk("sat.u0", {16'b0, n0}, 32'h5);
        clr = 1'b1; step();
        chk("clrwin.u0", {16'b0, n0}, 32'h0);
        chk("clrwin.u1", {30'b0, n1}, 32'h0);
        chk("clrwin.pulse", {31'b0, c0}, 32'h1);
        idle();

        // Random traffic on a few addresses to provoke collisions
        repeat (400) begin
            for (int p = 0; p < 2; p++)
                set(p, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)),
                    8'h80 + 8'($urandom_range(0, 3)), $urandom);
            clr = ($urandom_range(0, 19) == 0);
            step();
        end
        idle(); step();

        // Async reset between the read edge and the output edge
        set(0, 1'b1, 1'b0, 4'h0, 8'h10, 32'h0);
        set(1, 1'b1, 1'b0, 4'h0, 8'h30, 32'h0); step();
        idle();
        #2 rst_n = 1'b0;
        #1;
        chk("rst.u0.va", {31'b0, va0}, 32'h0);
        chk("rst.u0.da", da0, 32'h0);
        chk("rst.u1.va", {31'b0, va1}, 32'h0);
        chk("rst.u1.da", da1, 32'h0);
        chk("rst.u0.cnt", {16'b0, n0}, 32'h0);
        model_reset();
        #1 rst_n = 1'b1;
        set(0, 1'b1, 1'b0, 4'h0, 8'h10, 32'h0);
        set(1, 1'b1, 1'b0, 4'h0, 8'h40, 32'h0); step();
        chk("persist.u0", da0, 32'hAABB1122);
        chk("persist.u0.b", db0, 32'hAAAABBBB);
        idle(); step();
        chk("persist.u1", da1, 32'hAABB1122);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dual_port_ram_be.md
Name: dual_port_ram_be

Overview:
- Parametrised true dual-port synchronous RAM with per-byte write enables.
- Selectable read-during-write mode and selectable write-collision priority.
- Optional output pipeline register, per-port read-valid flags and a saturating collision counter.
- Next-generation shared scratch memory between the compute datapath and the host/DMA side of the memory subsystem.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8, address width; depth = 2**ADDR_WIDTH words.
- NB, DATA_WIDTH/8, number of byte lanes (derived, not overridden).
- RDW_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new data).
- PRIORITY, 0, collision winner on overlapping bytes: 0 = port A, 1 = port B.
- OUT_REG, 0, 1 adds an output register stage (read latency 2 instead of 1).
- CNT_WIDTH, 16, collision counter width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en_a  in  1  port A access enable.
- we_a  in  1  port A write (qualified by en_a).
- be_a  in  NB  port A byte enables (qualified by en_a & we_a).
- addr_a  in  ADDR_WIDTH  port A address.
- din_a  in  DATA_WIDTH  port A write data.
- dout_a  out  DATA_WIDTH  port A read data.
- valid_a  out  1  dout_a holds data for an en_a access.
- en_b, we_b, be_b, addr_b, din_b, dout_b, valid_b: port B equivalents.
- collision  out  1  one-cycle pulse for a write collision on the previous edge.
- clr_cnt  in  1  synchronous clear of collision_cnt.
- collision_cnt  out  CNT_WIDTH  saturating count of collision events.

Behaviour:
- Reset (rst_n=0, async): dout_a, dout_b, valid_a, valid_b, collision and collision_cnt go to 0; all pipeline registers clear. Memory array is not reset; contents persist through reset.
- Access: every en_x=1 edge is a read of addr_x. If we_x=1 it is also a write of the din_x lanes with be_x[i]=1; be_x=0 means no write.
- Latency, OUT_REG=0: dout_x and valid_x=1 appear after the edge that samples the access (1 cycle).
- Latency, OUT_REG=1: one cycle later (2 cycles).
- valid_x is 0 in cycles following en_x=0. dout_x holds its last value when not valid.
- Same-port read-during-write: RDW_MODE=0 returns pre-write word. RDW_MODE=1 returns the word after the write, with non-enabled lanes keeping old bytes.
- Cross-port read-during-write (A reads the address B writes in the same cycle, or vice versa): always returns old data.
- Collision condition: en_a&we_a&en_b&we_b, addr_a==addr_b and (be_a&be_b)!=0.
- On collision, overlapping lanes take the PRIORITY port's data. Non-overlapping lanes take whichever port enabled them, so the words merge.
- Same address with disjoint be: both lanes written, no collision flagged.
- collision is registered: 1 for exactly the cycle after the colliding edge. Back-to-back collisions hold it high.
- collision_cnt increments by 1 per collision edge and saturates at 2**CNT_WIDTH-1.
- clr_cnt=1 zeroes collision_cnt on the next edge, taking precedence over a simultaneous increment. The collision pulse still fires.
- Reset asserted mid-access: in-flight reads are discarded (valid=0). A write sampled on an edge before reset asserted is committed.
- Address wrap: none. Addresses are a full 2**ADDR_WIDTH range; no out-of-range case exists.

Test Plan:
- Byte-lane write: DATA_WIDTH=32, A writes 0xAABBCCDD to 0x10 with be=1111, then 0x00001122 with be=0011, then reads 0x10 -> dout_a=0xAABB1122, valid_a=1 one cycle after the read edge (OUT_REG=0), or two cycles (OUT_REG=1).
- Same-port RDW: 0x20 holds 0x11111111; A writes 0x22222222 with read on the same edge -> dout_a=0x11111111 (RDW_MODE=0) or 0x22222222 (RDW_MODE=1).
- Cross-port RDW: B reads 0x20 while A writes 0x33333333 -> dout_b=old 0x22222222. Next B read -> 0x33333333.
- Collision merge, PRIORITY=0: A writes 0xCCCCCCCC be=1100 and B writes 0xDDDDDDDD be=0110, both to 0x30 -> collision=1 for one cycle, collision_cnt=1, read 0x30 = 0xCCCCDDxx (lane0 unchanged). With PRIORITY=1 -> 0xCCDDDDxx.
- Disjoint lanes: same address, be_a=1100, be_b=0011 -> collision stays 0, word is fully merged. Counter saturation: CNT_WIDTH=2, five collisions -> collision_cnt=3. clr_cnt with a collision on the same edge -> collision_cnt=0.
- Async reset mid-read: assert rst_n=0 between the read edge and the output edge -> valid_a=0 and dout_a=0 immediately. After release, a read of a previously written address returns its pre-reset contents.
